// File: rtl/gate_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gate_scan_pkg
// Description : Shared types, constants and reference function for the
//               gate truth-table scanner.
// Revision    : 1.0 - initial release
// ============================================================================
package gate_scan_pkg;

  localparam int GATE_W = 7;
  localparam int ROWS   = 4;

  // Bit positions of each gate result inside a gate vector
  localparam int AND_B  = 0;
  localparam int OR_B   = 1;
  localparam int NOTA_B = 2;
  localparam int NAND_B = 3;
  localparam int NOR_B  = 4;
  localparam int XOR_B  = 5;
  localparam int XNOR_B = 6;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  // Reference gate vector a correctly working gate block returns for {a,b}
  function automatic logic [GATE_W-1:0] expected_vec(input logic a, input logic b);
    logic [GATE_W-1:0] v;
    v         = '0;
    v[AND_B]  = a & b;
    v[OR_B]   = a | b;
    v[NOTA_B] = ~a;
    v[NAND_B] = ~(a & b);
    v[NOR_B]  = ~(a | b);
    v[XOR_B]  = a ^ b;
    v[XNOR_B] = ~(a ^ b);
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gate_truth_scanner.sv
`default_nettype none
// ============================================================================
// Module      : gate_truth_scanner
// Description : Drives all four {a,b} operand rows into an external gate
//               block, waits SETTLE_CYCLES per row, captures the 7 gate
//               results into a 28-bit truth table and counts bad rows.
// Revision    : 1.0 - initial release
// ============================================================================
module gate_truth_scanner
  import gate_scan_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [GATE_W-1:0]      gate_in,
  output logic                   a_out,
  output logic                   b_out,
  output logic                   busy,
  output logic                   done,
  output logic                   valid,
  output logic [ROWS*GATE_W-1:0] table_out,
  output logic [2:0]             mismatch_cnt
);

  // Settle counter compares against the last settle cycle index
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [1:0] LAST_ROW    = 2'(ROWS - 1);

  state_t                  state_q,  state_d;
  logic [1:0]              row_q,    row_d;
  logic [3:0]              cnt_q,    cnt_d;
  logic                    valid_q,  valid_d;
  logic [ROWS*GATE_W-1:0]  table_q,  table_d;
  logic [2:0]              mism_q,   mism_d;

  // Next-state logic: sequencing, row advance, capture and mismatch count
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    table_d = table_q;
    mism_d  = mism_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SETTLE;
          row_d   = 2'd0;
          cnt_d   = 4'd0;
          valid_d = 1'b0;
          mism_d  = 3'd0;
          table_d = '0;
        end
      end
      SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = CAPTURE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      CAPTURE: begin
        table_d[int'(row_q)*GATE_W +: GATE_W] = gate_in;
        if (gate_in != expected_vec(row_q[1], row_q[0])) begin
          mism_d = mism_q + 3'd1;
        end
        cnt_d = 4'd0;
        if (row_q == LAST_ROW) begin
          state_d = DONE;
        end else begin
          state_d = SETTLE;
          row_d   = row_q + 2'd1;
        end
      end
      DONE: begin
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers, cleared asynchronously so a scan can be aborted anytime
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      row_q   <= 2'd0;
      cnt_q   <= 4'd0;
      valid_q <= 1'b0;
      table_q <= '0;
      mism_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      table_q <= table_d;
      mism_q  <= mism_d;
    end
  end

  // Operands come straight from the row register, so they stay glitch-free
  // and keep the last driven row while idle
  assign a_out        = row_q[1];
  assign b_out        = row_q[0];
  assign busy         = (state_q == SETTLE) || (state_q == CAPTURE);
  assign done         = (state_q == DONE);
  assign valid        = valid_q;
  assign table_out    = table_q;
  assign mismatch_cnt = mism_q;

endmodule
`default_nettype wire

// File: tb/tb_gate_truth_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_gate_truth_scanner
// Description : Directed self-checking bench for gate_truth_scanner.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gate_truth_scanner;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start1 = 1'b0, start2 = 1'b0;
  logic        stuck = 1'b0, dly2 = 1'b0;
  logic [6:0]  gate1, gate2, d1_q = 7'd0, d2_q = 7'd0;
  logic        a1, b1, busy1, done1, valid1;
  logic        a2, b2, busy2, done2, valid2;
  logic [27:0] tab1, tab2, first_tab;
  logic [2:0]  mism1, mism2;
  int          total = 0, bad = 0, de = 0, ndone = 0;

  always #5 clk = ~clk;

  gate_truth_scanner #(.SETTLE_CYCLES(2)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .gate_in(gate1),
    .a_out(a1), .b_out(b1), .busy(busy1), .done(done1), .valid(valid1),
    .table_out(tab1), .mismatch_cnt(mism1));

  gate_truth_scanner #(.SETTLE_CYCLES(1)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .gate_in(gate2),
    .a_out(a2), .b_out(b2), .busy(busy2), .done(done2), .valid(valid2),
    .table_out(tab2), .mismatch_cnt(mism2));

  // Hand-written truth table of a healthy gate block
  function automatic logic [6:0] gm(input logic a, input logic b);
    case ({a, b})
      2'b00:   return 7'h5C;
      2'b01:   return 7'h2E;
      2'b10:   return 7'h2A;
      default: return 7'h43;
    endcase
  endfunction

  assign gate1 = gm(a1, b1) & {6'h3F, ~stuck};

  // Gate block with one or two cycles of output latency
  always @(posedge clk) begin
    d1_q <= gm(a2, b2);
    d2_q <= d1_q;
  end
  assign gate2 = dly2 ? d2_q : d1_q;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Pulse start for one edge and return the edge index at which done is seen
  task automatic scan(input int sel, output int edge_n);
    edge_n = -1;
    if (sel == 1) start1 = 1'b1; else start2 = 1'b1;
    tick;
    start1 = 1'b0;
    start2 = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      tick;
      if ((sel == 1) ? done1 : done2) begin
        edge_n = i;
        break;
      end
    end
  endtask

  initial begin
    // Reset
    tick; tick;
    chk("rst_table", 32'(tab1), 32'h0);
    chk("rst_flags", {a1, b1, busy1, done1, valid1, mism1}, 32'h0);
    rst = 1'b0;
    tick;
    chk("idle_hold", {tab1, busy1, done1, valid1}, 32'h0);

    // Nominal scan
    scan(1, de);
    chk("nom_done_edge", 32'(de), 32'd12);
    chk("nom_table", 32'(tab1), 32'h86A975C);
    chk("nom_mism", 32'(mism1), 32'd0);
    tick;
    chk("nom_valid", {valid1, done1, busy1}, 32'b100);
    chk("nom_ab_hold", {a1, b1}, 32'b11);
    first_tab = tab1;

    // AND output stuck at 0 only affects row 3
    stuck = 1'b1;
    scan(1, de);
    tick;
    chk("stuck_table", 32'(tab1), 32'h84A975C);
    chk("stuck_mism", 32'(mism1), 32'd1);
    stuck = 1'b0;

    // start held high for 20 cycles
    ndone = 0;
    start1 = 1'b1;
    tick;
    for (int i = 1; i <= 19; i++) begin
      tick;
      if (done1) ndone++;
      if (i == 1)  chk("held_busy_e1", 32'(busy1), 32'd1);
      if (i == 11) chk("held_busy_e11", 32'(busy1), 32'd1);
      if (i == 12) chk("held_done_e12", {busy1, done1}, 32'b01);
    end
    start1 = 1'b0;
    chk("held_one_done", 32'(ndone), 32'd1);
    for (int i = 0; i < 40 && !done1; i++) tick;
    tick;

    // Asynchronous reset at edge 6 of a scan
    start1 = 1'b1;
    tick;
    start1 = 1'b0;
    for (int i = 1; i <= 6; i++) tick;
    chk("pre_rst_busy", {busy1, a1}, 32'b11);
    rst = 1'b1;
    #1;
    chk("arst_table", 32'(tab1), 32'h0);
    chk("arst_flags", {a1, b1, busy1, done1, valid1, mism1}, 32'h0);
    tick;
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      tick;
      if (done1 || busy1) ndone++;
    end
    chk("arst_no_scan", 32'(ndone), 32'd0);
    scan(1, de);
    chk("arst_rescan_edge", 32'(de), 32'd12);
    chk("arst_rescan_tab", 32'(tab1), 32'h86A975C);

    // Back-to-back: new start in the cycle right after done
    tick;
    chk("b2b_valid1", 32'(valid1), 32'd1);
    start1 = 1'b1;
    tick;
    start1 = 1'b0;
    chk("b2b_clear", {valid1, tab1}, 32'h0);
    de = -1;
    for (int i = 1; i <= 40; i++) begin
      tick;
      if (done1) begin de = i; break; end
    end
    chk("b2b_edge", 32'(de), 32'd12);
    chk("b2b_same", 32'(tab1), 32'(first_tab));
    chk("b2b_mism", 32'(mism1), 32'd0);

    // SETTLE_CYCLES=1 with one cycle of gate latency
    dly2 = 1'b0;
    scan(2, de);
    chk("s1_done_edge", 32'(de), 32'd8);
    chk("s1_table", 32'(tab2), 32'h86A975C);
    chk("s1_mism", 32'(mism2), 32'd0);
    tick;

    // Two cycles of latency is too slow for one settle cycle
    dly2 = 1'b1;
    scan(2, de);
    tick;
    chk("s1_slow_mism", 32'(mism2 != 3'd0), 32'd1);
    chk("s1_slow_valid", 32'(valid2), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
